arm1_control_unit: RTL and testbench
====================================

Name: arm1_control_unit

Overview:
Multi-cycle fetch/execute sequencer for the ARM1 8-bit accumulator core, and the only master of the 16x8 unified program/data memory.
- Drives the memory's address, write-enable and write data, and consumes its combinational read data.
- Holds PC, IR, accumulator A, operand register B and Z/C flags.
- Executes the 4-bit-opcode/4-bit-address instruction set.
- Presents OUT results on a valid/ready port.

Parameters:
- DATA_W, 8: data and instruction width. Only 8 is supported.
- ADDR_W, 4: memory address width. Must equal DATA_W-4.
- AUTO_START, 0: 1 = leave IDLE on the first clock after reset without waiting for start.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse that begins execution from IDLE
- mem_address  out  ADDR_W  memory address, combinational from state
- mem_write  out  1  memory write enable; the memory writes on the same rising edge
- mem_wdata  out  DATA_W  memory write data, always equal to A
- mem_rdata  in  DATA_W  memory read data, combinational from mem_address
- out_data  out  DATA_W  OUT result, registered
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- halted  out  1  high in HALT
- pc_dbg  out  ADDR_W  current PC
- acc_dbg  out  DATA_W  current A

Behaviour:
Reset (async, rst_n=0):
- State=IDLE; PC, IR, A, B, Z, C, out_data = 0.
- out_valid=0, halted=0, mem_write=0, mem_address=0.
- Asserting reset mid-instruction aborts it immediately; out_valid drops asynchronously.

States: IDLE, FETCH, EXEC, OUTWAIT, HALT.
- IDLE: mem_address=PC. Go to FETCH when start=1, or unconditionally when AUTO_START=1.
- FETCH: mem_address=PC. At the edge: IR<=mem_rdata; PC<=PC+1 mod 16 (15 wraps to 0). Next state EXEC.
- EXEC: mem_address=IR[3:0]. Opcode is IR[7:4]; the operand address is IR[3:0]. Next state FETCH unless noted.
- OUTWAIT: hold out_valid=1 and out_data stable. On out_valid & out_ready at an edge: out_valid<=0, go to FETCH.
- HALT: halted=1, mem_write=0. Stays here until reset; start is ignored.

Opcodes (executed in EXEC):
- 0000 ADD: {C,A}<=A+B (9-bit sum; C = carry-out).
- 0001 SUB: A<=A-B mod 256; C<=1 when A<B (borrow).
- 0010 OR: A<=A|B. 0011 AND: A<=A&B. 0100 XOR: A<=A^B. Logic ops clear C.
- Z: every ALU op and LDA set Z = (new A==0).
- 1000 JMP: PC<=IR[3:0].
- 1001 JZ: PC<=IR[3:0] if Z=1, else PC unchanged.
- 1010 OUT: out_data<=A, out_valid<=1, go to OUTWAIT.
- 1100 LDA: A<=mem_rdata. 1101 LDB: B<=mem_rdata (flags unchanged).
- 1110 STR: mem_write=1 in EXEC, mem_wdata=A.
- 1111 HLT: go to HALT.
- 0101, 0110, 0111, 1011: NOP.

General rules:
- mem_write is high only in EXEC with STR.
- Each instruction takes 2 cycles, plus OUT backpressure cycles.
- A start pulse outside IDLE is ignored.
- Self-modifying code is legal: a STR to an address not yet fetched is seen by the later fetch.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Memory holds LDA 12, LDB 13, ADD, OR, STR 14, OUT, HLT with mem[12]=05 and mem[13]=03; pulse start, out_ready=1 -> after ADD A=08 (C=0, Z=0); after OR A=0B; mem[14]=0B; one out_valid beat with out_data=0B; halted=1 with pc_dbg=7 after 15 cycles of execution.
- Same program with out_ready held low for 5 cycles -> out_valid stays 1 with out_data=0B stable throughout; HLT is fetched only after the handshake; exactly one beat is transferred.
- A=03, B=05, SUB -> A=FE, C=1, Z=0. A=05, B=05, SUB -> A=00, C=0, Z=1; a following JZ 9 loads PC=9. Z=0 -> JZ falls through.
- Program of NOPs with JMP 15 at address 15 and nothing else -> PC wraps 15->0 on the fetch increment, then the jump executes; a NOP at 15 continues execution at 0.
- rst_n dropped while in OUTWAIT and while in EXEC for STR -> out_valid and mem_write go low without a clock; all state reads 0; after release the core sits in IDLE until start (AUTO_START=0).
- start pulses issued during execution and in HALT -> no effect; halted remains 1.

Source files
------------

// File: rtl/arm1_control_unit.sv
// arm1_control_unit
// Multi-cycle fetch/execute sequencer for the ARM1 8-bit accumulator core.
// It is the only master of the 16x8 unified program/data memory.
// Every instruction takes a FETCH cycle and an EXEC cycle. OUT adds an
// OUTWAIT state that holds the result until the consumer accepts it.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse that leaves IDLE
//   mem_address  memory address (PC in IDLE/FETCH/OUTWAIT/HALT, IR operand in EXEC)
//   mem_write    memory write enable; only in EXEC of STR
//   mem_wdata    memory write data (always the accumulator)
//   mem_rdata    combinational memory read data
//   out_data     registered OUT result
//   out_valid    out_data valid
//   out_ready    consumer accepts out_data
//   halted       high in HALT
//   pc_dbg       current program counter
//   acc_dbg      current accumulator
module arm1_control_unit #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int AUTO_START = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] acc_dbg
);

  localparam int OP_W = DATA_W - ADDR_W;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1000;
  localparam logic [OP_W-1:0] OP_JZ  = 4'b1001;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1010;
  localparam logic [OP_W-1:0] OP_LDA = 4'b1100;
  localparam logic [OP_W-1:0] OP_LDB = 4'b1101;
  localparam logic [OP_W-1:0] OP_STR = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUTWAIT,
    S_HALT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b_reg;
  logic              zero;
  logic              carry;

  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   alu_res;

  // ALU result with the carry/borrow in the top bit. A 9-bit subtraction
  // leaves bit 8 set exactly when acc < b, which is the borrow.
  function automatic logic [DATA_W:0] alu_op(input logic [OP_W-1:0]   op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_OR:   r = {1'b0, a | b};
      OP_AND:  r = {1'b0, a & b};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign opcode  = ir[DATA_W-1:ADDR_W];
  assign operand = ir[ADDR_W-1:0];
  assign alu_res = alu_op(opcode, acc, b_reg);

  // Address and write strobe decode straight from state, so reset removes
  // them without waiting for a clock.
  always_comb begin
    mem_address = pc;
    if (state == S_EXEC) mem_address = operand;
  end

  assign mem_write = (state == S_EXEC) && (opcode == OP_STR);
  assign mem_wdata = acc;
  assign halted    = (state == S_HALT);
  assign pc_dbg    = pc;
  assign acc_dbg   = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      acc       <= '0;
      b_reg     <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start || (AUTO_START != 0)) state <= S_FETCH;
        end

        S_FETCH: begin
          ir    <= mem_rdata;
          pc    <= pc + 1'b1;  // wraps naturally at the address width
          state <= S_EXEC;
        end

        S_EXEC: begin
          state <= S_FETCH;
          case (opcode)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR: begin
              acc   <= alu_res[DATA_W-1:0];
              carry <= alu_res[DATA_W];
              zero  <= (alu_res[DATA_W-1:0] == '0);
            end
            OP_JMP: pc <= operand;
            OP_JZ:  if (zero) pc <= operand;
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
              state     <= S_OUTWAIT;
            end
            OP_LDA: begin
              acc  <= mem_rdata;
              zero <= (mem_rdata == '0);
            end
            OP_LDB: b_reg <= mem_rdata;
            OP_HLT: state <= S_HALT;
            default: ;  // STR is handled by the write strobe; others are NOPs
          endcase
        end

        S_OUTWAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_FETCH;
          end
        end

        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm1_control_unit.sv
// tb_arm1_control_unit
// Directed bench for arm1_control_unit. It models the 16x8 memory
// (combinational read, write on the rising edge), drives start and
// out_ready, and checks outputs 1 time unit after each rising edge.
module tb_arm1_control_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] mem_address;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       halted;
  logic [3:0] pc_dbg;
  logic [7:0] acc_dbg;

  logic [7:0] mem [16];
  int         beats;
  int         passed;
  int         total;

  arm1_control_unit #(.DATA_W(8), .ADDR_W(4), .AUTO_START(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_address(mem_address),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted),
    .pc_dbg     (pc_dbg),
    .acc_dbg    (acc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] = mem_wdata;
    if (out_valid && out_ready) beats = beats + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic clear_mem(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) mem[i] = fill;
  endtask

  // LDA 12, LDB 13, ADD, OR, STR 14, OUT, HLT ; mem[12]=05, mem[13]=03
  task automatic load_prog1();
    clear_mem(8'h00);
    mem[0] = 8'hCC; mem[1] = 8'hDD; mem[2] = 8'h00; mem[3] = 8'h20;
    mem[4] = 8'hEE; mem[5] = 8'hA0; mem[6] = 8'hF0;
    mem[12] = 8'h05; mem[13] = 8'h03;
  endtask

  task automatic do_reset();
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    step(1);
    beats = 0;
  endtask

  // The core leaves IDLE on the edge that samples start.
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    load_prog1();
    rst_n = 1'b0;
    #3;
    chk("reset out_valid", {7'b0, out_valid}, 8'h00);
    chk("reset halted", {7'b0, halted}, 8'h00);
    chk("reset mem_write", {7'b0, mem_write}, 8'h00);
    chk("reset mem_address", {4'b0, mem_address}, 8'h00);
    chk("reset pc", {4'b0, pc_dbg}, 8'h00);
    chk("reset acc", acc_dbg, 8'h00);
    chk("reset out_data", out_data, 8'h00);
    rst_n = 1'b1;
    step(3);
    chk("idle holds pc", {4'b0, pc_dbg}, 8'h00);
  endtask

  task automatic test_program();
    load_prog1();
    out_ready = 1'b1;
    do_reset();
    pulse_start();
    step(2);
    chk("LDA A", acc_dbg, 8'h05);
    step(4);
    chk("ADD A", acc_dbg, 8'h08);
    chk("ADD C", {7'b0, dut.carry}, 8'h00);
    chk("ADD Z", {7'b0, dut.zero}, 8'h00);
    step(2);
    chk("OR A", acc_dbg, 8'h0B);
    step(1);
    chk("STR mem_write", {7'b0, mem_write}, 8'h01);
    chk("STR address", {4'b0, mem_address}, 8'h0E);
    chk("STR wdata", mem_wdata, 8'h0B);
    step(1);
    chk("STR mem[14]", mem[14], 8'h0B);
    chk("after STR mem_write", {7'b0, mem_write}, 8'h00);
    step(2);
    chk("OUT valid", {7'b0, out_valid}, 8'h01);
    chk("OUT data", out_data, 8'h0B);
    step(1);
    chk("OUT valid drop", {7'b0, out_valid}, 8'h00);
    chk("halted before HLT", {7'b0, halted}, 8'h00);
    step(2);
    chk("halted", {7'b0, halted}, 8'h01);
    chk("halt pc", {4'b0, pc_dbg}, 8'h07);
    chk("beats", beats[7:0], 8'h01);
  endtask

  task automatic test_backpressure();
    load_prog1();
    out_ready = 1'b0;
    do_reset();
    pulse_start();
    step(12);
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", {7'b0, out_valid}, 8'h01);
      chk("bp data", out_data, 8'h0B);
      chk("bp pc", {4'b0, pc_dbg}, 8'h06);
      chk("bp halted", {7'b0, halted}, 8'h00);
      step(1);
    end
    chk("bp beats before", beats[7:0], 8'h00);
    out_ready = 1'b1;
    step(1);
    chk("bp valid drop", {7'b0, out_valid}, 8'h00);
    chk("bp beats", beats[7:0], 8'h01);
    step(2);
    chk("bp halted", {7'b0, halted}, 8'h01);
    chk("bp halt pc", {4'b0, pc_dbg}, 8'h07);
    chk("bp beats end", beats[7:0], 8'h01);
  endtask

  task automatic test_sub_jz();
    // 3 - 5 then JZ 9 falls through to HLT at 4
    clear_mem(8'h00);
    mem[0] = 8'hCC; mem[1] = 8'hDD; mem[2] = 8'h10; mem[3] = 8'h99;
    mem[4] = 8'hF0; mem[9] = 8'hF0;
    mem[12] = 8'h03; mem[13] = 8'h05;
    out_ready = 1'b1;
    do_reset();
    pulse_start();
    step(6);
    chk("SUB borrow A", acc_dbg, 8'hFE);
    chk("SUB borrow C", {7'b0, dut.carry}, 8'h01);
    chk("SUB borrow Z", {7'b0, dut.zero}, 8'h00);
    step(2);
    chk("JZ fallthrough pc", {4'b0, pc_dbg}, 8'h04);
    step(2);
    chk("JZ fallthrough halt", {7'b0, halted}, 8'h01);

    // 5 - 5 then JZ 9 is taken
    mem[12] = 8'h05; mem[13] = 8'h05;
    do_reset();
    pulse_start();
    step(6);
    chk("SUB zero A", acc_dbg, 8'h00);
    chk("SUB zero C", {7'b0, dut.carry}, 8'h00);
    chk("SUB zero Z", {7'b0, dut.zero}, 8'h01);
    step(2);
    chk("JZ taken pc", {4'b0, pc_dbg}, 8'h09);
    step(2);
    chk("JZ taken halt", {7'b0, halted}, 8'h01);
    chk("JZ taken halt pc", {4'b0, pc_dbg}, 8'h0A);
  endtask

  task automatic test_pc_wrap();
    clear_mem(8'h50);
    mem[15] = 8'h8F;
    out_ready = 1'b1;
    do_reset();
    pulse_start();
    step(30);
    chk("wrap pre-fetch pc", {4'b0, pc_dbg}, 8'h0F);
    step(1);
    chk("wrap fetch pc", {4'b0, pc_dbg}, 8'h00);
    step(1);
    chk("wrap jmp pc", {4'b0, pc_dbg}, 8'h0F);
    step(1);
    chk("wrap refetch pc", {4'b0, pc_dbg}, 8'h00);

    mem[15] = 8'h50;
    do_reset();
    pulse_start();
    step(31);
    chk("nop15 fetch pc", {4'b0, pc_dbg}, 8'h00);
    step(2);
    chk("nop15 continues pc", {4'b0, pc_dbg}, 8'h01);
    chk("nop15 not halted", {7'b0, halted}, 8'h00);
  endtask

  task automatic test_async_reset();
    // reset while in OUTWAIT
    load_prog1();
    out_ready = 1'b0;
    do_reset();
    pulse_start();
    step(12);
    chk("ar outwait valid", {7'b0, out_valid}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar out_valid", {7'b0, out_valid}, 8'h00);
    chk("ar out_data", out_data, 8'h00);
    chk("ar acc", acc_dbg, 8'h00);
    chk("ar pc", {4'b0, pc_dbg}, 8'h00);
    step(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(4);
    chk("ar idle pc", {4'b0, pc_dbg}, 8'h00);
    chk("ar idle acc", acc_dbg, 8'h00);
    chk("ar idle valid", {7'b0, out_valid}, 8'h00);

    // reset while in EXEC of STR
    load_prog1();
    do_reset();
    pulse_start();
    step(9);
    chk("ar str mem_write", {7'b0, mem_write}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar str mem_write low", {7'b0, mem_write}, 8'h00);
    chk("ar str address", {4'b0, mem_address}, 8'h00);
    chk("ar str acc", acc_dbg, 8'h00);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("ar str mem[14]", mem[14], 8'h00);
    chk("ar str idle pc", {4'b0, pc_dbg}, 8'h00);
    pulse_start();
    step(2);
    chk("ar restart LDA", acc_dbg, 8'h05);
  endtask

  task automatic test_start_ignored();
    load_prog1();
    out_ready = 1'b1;
    do_reset();
    pulse_start();
    step(3);
    pulse_start();  // during execution
    step(3);
    chk("si ADD A", acc_dbg, 8'h08);
    step(8);
    chk("si halted", {7'b0, halted}, 8'h01);
    chk("si pc", {4'b0, pc_dbg}, 8'h07);
    pulse_start();  // in HALT
    step(3);
    chk("si still halted", {7'b0, halted}, 8'h01);
    chk("si halt pc", {4'b0, pc_dbg}, 8'h07);
    chk("si beats", beats[7:0], 8'h01);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    beats     = 0;
    start     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    clear_mem(8'h00);
    test_reset();
    test_program();
    test_backpressure();
    test_sub_jz();
    test_pc_wrap();
    test_async_reset();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
